// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Handshake and operand/result bundle between the control unit and the
// sequential divider.
//   master : control unit  - drives start/is_signed/a/b, observes results
//   slave  : seq_divider   - consumes the request, drives busy/done/flags/hi/lo
// Signals:
//   start     request, honoured only while busy=0
//   is_signed 1 = signed (DIV), 0 = unsigned (DIVU)
//   a, b      dividend, divisor (WIDTH bits)
//   busy      operation in flight
//   done      one-cycle pulse when hi/lo/div_zero are valid
//   div_zero  sticky divide-by-zero flag for the last accepted operation
//   hi, lo    remainder, quotient
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider serving signed (DIV) and unsigned (DIVU)
// division. Quotient goes to lo, remainder to hi. Quotient truncates toward
// zero, remainder carries the sign of the dividend.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation without a done pulse
//   bus    seq_divider_if.slave (start/is_signed/a/b in; busy/done/div_zero/hi/lo out)
// Configuration:
//   SEQ_DIVIDER_EARLY_EXIT_EN - when defined, the bit counter starts at the
//   highest set bit of |a| instead of WIDTH-1, shortening the run.
// Latency (feature off): done high WIDTH+1 cycles after the start edge;
// divide-by-zero completes 1 cycle after the start edge.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [CNT_W-1:0] count_init_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;

    // Two's-complement magnitude, applied only to negative signed operands.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? (-v) : v;
    endfunction

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    // Index of the highest set bit; 0 when the value is zero.
    function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = CNT_W'(i);
            end
        end
        return idx;
    endfunction
`endif

    assign a_mag_s = magnitude(bus.a, bus.is_signed);
    assign b_mag_s = magnitude(bus.b, bus.is_signed);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    // Leading zero bits of the dividend contribute nothing; skip them.
    assign count_init_s = msb_index(a_mag_s);
`else
    assign count_init_s = CNT_W'(WIDTH - 1);
`endif

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            count_q   <= count_d;
        end
    end

    // Next-state, restoring-division step and result formatting.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        count_d   = count_q;
        // Partial remainder keeps its top bit so a divisor up to 2^WIDTH-1
        // (and the signed magnitude 2^(WIDTH-1)) never overflows the compare.
        trial_s   = {rem_q, dvd_q[count_q[IDX_W-1:0]]};
        diff_s    = trial_s - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d    = 1'b1;
                    neg_quo_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_d = bus.is_signed & bus.a[WIDTH-1];
                    dvd_d     = a_mag_s;
                    dvs_d     = b_mag_s;
                    rem_d     = '0;
                    quo_d     = '0;
                    count_d   = count_init_s;
                    if (bus.b == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!diff_s[WIDTH]) begin
                    rem_d = diff_s[WIDTH-1:0];
                    quo_d[count_q[IDX_W-1:0]] = 1'b1;
                end else begin
                    rem_d = trial_s[WIDTH-1:0];
                end
                if (count_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_FINISH: begin
                if (!dz_q) begin
                    lo_d = neg_quo_q ? (-quo_q) : quo_q;
                    hi_d = neg_rem_q ? (-rem_q) : rem_q;
                end else begin
                    lo_d = lo_q;
                    hi_d = hi_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider at WIDTH=32. Expected values
// are hand-computed; latencies depend on SEQ_DIVIDER_EARLY_EXIT_EN.
// ---------------------------------------------------------------------------
module tb_seq_divider;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests_run;
    int   fails;

    seq_divider_if #(.WIDTH(32)) dif ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request; returns 1 time unit after the edge that accepts it.
    task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.a         = av;
        dif.b         = bv;
        @(posedge clk); #1;
        dif.start     = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(input int start_cnt, output int lat);
        lat = start_cnt;
        while (dif.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ex_lo,
                          input logic [31:0] ex_hi, input logic ex_dz, input int ex_lat);
        int lat;
        launch(s, av, bv);
        wait_done(0, lat);
        check({tag, "_lat"},  32'(lat), 32'(ex_lat));
        check({tag, "_lo"},   dif.lo, ex_lo);
        check({tag, "_hi"},   dif.hi, ex_hi);
        check({tag, "_dz"},   {31'd0, dif.div_zero}, {31'd0, ex_dz});
        check({tag, "_busy"}, {31'd0, dif.busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int l_first;
        int pulses;
        tests_run     = 0;
        fails         = 0;
        reset         = 1'b1;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.a         = 32'd0;
        dif.b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        check("rst_dz",   {31'd0, dif.div_zero}, 32'd0);
        check("rst_hi",   dif.hi, 32'd0);
        check("rst_lo",   dif.lo, 32'd0);

        // 7/2 signed with cycle-by-cycle busy/done profile.
        l_first = EE ? 4 : 33;
        launch(1'b1, 32'd7, 32'd2);
        check("s7_2_busy0", {31'd0, dif.busy}, 32'd1);
        for (int cyc = 1; cyc <= l_first; cyc++) begin
            @(posedge clk); #1;
            check($sformatf("s7_2_busy_c%0d", cyc), {31'd0, dif.busy}, (cyc < l_first) ? 32'd1 : 32'd0);
            check($sformatf("s7_2_done_c%0d", cyc), {31'd0, dif.done}, (cyc == l_first) ? 32'd1 : 32'd0);
        end
        check("s7_2_lo", dif.lo, 32'h0000_0003);
        check("s7_2_hi", dif.hi, 32'h0000_0001);
        @(posedge clk); #1;
        check("s7_2_done_pulse", {31'd0, dif.done}, 32'd0);

        run_op("sm7_2",  1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, EE ? 4 : 33);
        run_op("s7_m2",  1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, EE ? 4 : 33);
        run_op("u_fff0", 1'b0, 32'hFFFF_FFF0, 32'h10, 32'h0FFF_FFFF, 32'h0, 1'b0, 33);
        run_op("s_imin", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33);
        run_op("u_big",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b0, 33);

        // 7/2, then divide-by-zero started in the done cycle, then recovery.
        run_op("c7_2", 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, EE ? 4 : 33);
        run_op("c9_0", 1'b1, 32'd9, 32'd0, 32'd3, 32'd1, 1'b1, 1);
        launch(1'b1, 32'd9, 32'd3);
        check("c9_3_dz_clr", {31'd0, dif.div_zero}, 32'd0);
        wait_done(0, lat);
        check("c9_3_lat", 32'(lat), EE ? 32'd5 : 32'd33);
        check("c9_3_lo", dif.lo, 32'd3);
        check("c9_3_hi", dif.hi, 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation aborts without a done pulse.
        launch(1'b1, 32'd100, 32'd7);
        repeat (EE ? 2 : 9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, dif.busy}, 32'd0);
        check("abort_lo", dif.lo, 32'd0);
        check("abort_hi", dif.hi, 32'd0);
        check("abort_done", {31'd0, dif.done}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // A start while busy is ignored.
        launch(1'b1, 32'd100, 32'd7);
        @(posedge clk); #1;
        dif.start     = 1'b1;
        dif.is_signed = 1'b1;
        dif.a         = 32'd50;
        dif.b         = 32'd5;
        @(posedge clk); #1;
        dif.start     = 1'b0;
        wait_done(2, lat);
        check("busy_start_lat", 32'(lat), EE ? 32'd8 : 32'd33);
        check("busy_start_lo", dif.lo, 32'd14);
        check("busy_start_hi", dif.hi, 32'd2);
        @(posedge clk); #1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1) pulses++;
        end
        check("busy_start_no_2nd", 32'(pulses), 32'd0);

        // Early-exit vectors (fixed latency when the feature is off).
        run_op("e5_2", 1'b1, 32'd5, 32'd2, 32'd2, 32'd1, 1'b0, EE ? 4 : 33);
        run_op("e0_3", 1'b1, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, EE ? 2 : 33);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
